// File: rtl/rgr_pkg.sv
// Shared types and default sizing for the RGR serial front end.
package rgr_pkg;

  localparam int unsigned CNT_W_DEF       = 5;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises raw SCK and CS_n into the i_clk domain and detects the
// selected SCK edge; CS_n is passed on as a synchronised level only.
module sync_edge_det
  import rgr_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_en,
  input  logic i_edge_sel,
  output logic o_cs_n_sync,
  output logic o_sck_evt_c
);

  logic [STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [STAGES-1:0] cs_sync_q, cs_sync_d;
  logic              sck_prev_q, sck_prev_d;
  logic              sck_lvl;

  always_comb begin
    sck_sync_d = {sck_sync_q[STAGES-2:0], i_sck};
    cs_sync_d  = {cs_sync_q[STAGES-2:0], i_cs_n};
    sck_prev_d = sck_sync_q[STAGES-1];
  end

  // CS_n resets to deasserted so a fresh low must be observed after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      cs_sync_q  <= cs_sync_d;
      sck_prev_q <= sck_prev_d;
    end
  end

  assign sck_lvl     = sck_sync_q[STAGES-1];
  assign o_cs_n_sync = cs_sync_q[STAGES-1];
  assign o_sck_evt_c = i_en & (i_edge_sel ? (sck_prev_q & ~sck_lvl)
                                          : (~sck_prev_q & sck_lvl));

endmodule

// File: rtl/sck_frame_counter.sv
// SPI-slave bit/frame counter: counts selected SCK edges up to a run-time
// frame length and flags frame done, abort and overrun.
module sck_frame_counter
  import rgr_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sck,
  input  logic             i_cs_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_edge_sel,
  input  logic             i_auto,
  input  logic [CNT_W-1:0] i_len,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sck_evt,
  output logic             o_last,
  output logic             o_done,
  output logic             o_abort,
  output logic             o_ovf,
  output logic [7:0]       o_frames
);

  localparam int unsigned FRM_W = 8;
  localparam int unsigned CMP_W = CNT_W + 1;

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] frames_q, frames_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             sck_evt_q, sck_evt_d;
  logic             cs_n_sync;
  logic             sck_evt_c;
  logic [CMP_W-1:0] cnt_inc_c;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sck       (i_sck),
    .i_cs_n      (i_cs_n),
    .i_en        (i_en),
    .i_edge_sel  (i_edge_sel),
    .o_cs_n_sync (cs_n_sync),
    .o_sck_evt_c (sck_evt_c)
  );

  // Extra bit so a shortened i_len below the count still terminates the frame.
  assign cnt_inc_c = {1'b0, cnt_q} + CMP_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frames_d  = frames_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    sck_evt_d = sck_evt_c;
    if (i_clr) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      frames_d = '0;
      ovf_d    = 1'b0;
    end else if (i_en) begin
      if (cs_n_sync) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        abort_d = (state_q == ST_COUNT) && (cnt_q != '0);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_len != '0) begin
              state_d = ST_COUNT;
              cnt_d   = '0;
            end
          end
          ST_COUNT: begin
            if (sck_evt_c) begin
              if (cnt_inc_c >= {1'b0, i_len}) begin
                done_d   = 1'b1;
                frames_d = frames_q + FRM_W'(1);
                if (i_auto) begin
                  cnt_d = '0;
                end else begin
                  cnt_d   = i_len;
                  state_d = ST_HOLD;
                end
              end else begin
                cnt_d = cnt_inc_c[CNT_W-1:0];
              end
            end
          end
          ST_HOLD: begin
            if (sck_evt_c) ovf_d = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      frames_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      sck_evt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frames_q  <= frames_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      sck_evt_q <= sck_evt_d;
    end
  end

  assign o_cnt     = cnt_q;
  assign o_frames  = frames_q;
  assign o_ovf     = ovf_q;
  assign o_done    = done_q;
  assign o_abort   = abort_q;
  assign o_sck_evt = sck_evt_q;
  assign o_last    = (state_q == ST_COUNT) && (cnt_q == i_len - CNT_W'(1));

endmodule

// File: tb/tb_sck_frame_counter.sv
// Bench for sck_frame_counter: frame table, corner-case sequences and
// randomized frames checked against a frame-level arithmetic model.
module tb_sck_frame_counter;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_sck;
  logic       i_cs_n;
  logic       i_en;
  logic       i_clr;
  logic       i_edge_sel;
  logic       i_auto;
  logic [4:0] i_len;
  logic [4:0] o_cnt;
  logic       o_sck_evt;
  logic       o_last;
  logic       o_done;
  logic       o_abort;
  logic       o_ovf;
  logic [7:0] o_frames;

  sck_frame_counter dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sck      (i_sck),
    .i_cs_n     (i_cs_n),
    .i_en       (i_en),
    .i_clr      (i_clr),
    .i_edge_sel (i_edge_sel),
    .i_auto     (i_auto),
    .i_len      (i_len),
    .o_cnt      (o_cnt),
    .o_sck_evt  (o_sck_evt),
    .o_last     (o_last),
    .o_done     (o_done),
    .o_abort    (o_abort),
    .o_ovf      (o_ovf),
    .o_frames   (o_frames)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int cnt;
    int frames;
    int ovf;
    int last;
    int done;
    int abort;
  } obs_t;

  typedef struct {
    int   len;
    int   au;
    int   es;
    int   n;
    obs_t e;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  int done_seen  = 0;
  int abort_seen = 0;
  int m_frames = 0;
  int m_ovf    = 0;

  // Pulse monitors; each output pulse lasts exactly one cycle.
  always @(negedge i_clk) begin
    if (o_done)  done_seen  <= done_seen + 1;
    if (o_abort) abort_seen <= abort_seen + 1;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Each SCK phase lasts 3 i_clk cycles; idle level is low.
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      i_sck = 1'b1; tick(3);
      i_sck = 1'b0; tick(3);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".cnt"},    a.cnt,    e.cnt);
    chk({tag, ".frames"}, a.frames, e.frames);
    chk({tag, ".ovf"},    a.ovf,    e.ovf);
    chk({tag, ".last"},   a.last,   e.last);
    chk({tag, ".done"},   a.done,   e.done);
    chk({tag, ".abort"},  a.abort,  e.abort);
  endtask

  // One CS window of n SCK pulses; returns observations, then releases CS.
  task automatic run_vec(input int len, input int au, input int es, input int n,
                         input bit do_clr, output obs_t o, output int cnt_after);
    int d0, a0;
    i_len = 5'(len); i_auto = au[0]; i_edge_sel = es[0];
    if (do_clr) begin
      i_clr = 1'b1; tick(1); i_clr = 1'b0;
    end
    d0 = done_seen;
    i_cs_n = 1'b0; tick(5);
    pulses(n);
    tick(4);
    o.cnt = int'(o_cnt); o.frames = int'(o_frames); o.ovf = int'(o_ovf);
    o.last = int'(o_last); o.done = done_seen - d0;
    a0 = abort_seen;
    i_cs_n = 1'b1; tick(5);
    o.abort = abort_seen - a0;
    cnt_after = int'(o_cnt);
  endtask

  function automatic obs_t model(input int len, input int au, input int n);
    obs_t e;
    bit   in_cnt;
    e.done = 0; e.cnt = 0; e.ovf = m_ovf; in_cnt = 1'b0;
    if (len == 0) begin
      e.cnt = 0;
    end else if (au != 0) begin
      e.done = n / len; e.cnt = n % len; in_cnt = 1'b1;
    end else if (n >= len) begin
      e.done = 1; e.cnt = len;
      if (n > len) e.ovf = 1;
    end else begin
      e.cnt = n; in_cnt = 1'b1;
    end
    e.frames = (m_frames + e.done) % 256;
    e.last   = (in_cnt && e.cnt == len - 1) ? 1 : 0;
    e.abort  = (in_cnt && e.cnt != 0) ? 1 : 0;
    return e;
  endfunction

  vec_t tbl[13];

  initial begin
    obs_t o, e;
    int   ca, d0, a0, len, au, es, n;

    tbl[0]  = '{8,  0, 0, 8,   '{8,  1, 0, 0, 1,   0}};
    tbl[1]  = '{8,  0, 0, 9,   '{8,  1, 1, 0, 1,   0}};
    tbl[2]  = '{3,  1, 0, 9,   '{0,  3, 0, 0, 3,   0}};
    tbl[3]  = '{4,  0, 1, 4,   '{4,  1, 0, 0, 1,   0}};
    tbl[4]  = '{8,  0, 0, 5,   '{5,  0, 0, 0, 0,   1}};
    tbl[5]  = '{8,  0, 1, 7,   '{7,  0, 0, 1, 0,   1}};
    tbl[6]  = '{31, 0, 0, 30,  '{30, 0, 0, 1, 0,   1}};
    tbl[7]  = '{31, 0, 0, 31,  '{31, 1, 0, 0, 1,   0}};
    tbl[8]  = '{3,  1, 1, 4,   '{1,  1, 0, 0, 1,   1}};
    tbl[9]  = '{1,  1, 0, 5,   '{0,  5, 0, 1, 5,   0}};
    tbl[10] = '{0,  0, 0, 3,   '{0,  0, 0, 0, 0,   0}};
    tbl[11] = '{1,  1, 0, 256, '{0,  0, 0, 1, 256, 0}};
    tbl[12] = '{2,  0, 0, 5,   '{2,  1, 1, 0, 1,   0}};

    i_rst_n = 1'b0; i_sck = 1'b0; i_cs_n = 1'b1; i_en = 1'b1; i_clr = 1'b0;
    i_edge_sel = 1'b0; i_auto = 1'b0; i_len = 5'd8;
    tick(3);
    chk("rst.cnt", int'(o_cnt), 0);
    chk("rst.frames", int'(o_frames), 0);
    chk("rst.ovf", int'(o_ovf), 0);
    chk("rst.done", int'(o_done), 0);
    chk("rst.abort", int'(o_abort), 0);
    chk("rst.evt", int'(o_sck_evt), 0);
    chk("rst.last", int'(o_last), 0);
    i_rst_n = 1'b1; tick(2);

    for (int i = 0; i < 13; i++) begin
      run_vec(tbl[i].len, tbl[i].au, tbl[i].es, tbl[i].n, 1'b1, o, ca);
      chk_obs($sformatf("tbl%0d", i), o, tbl[i].e);
      chk($sformatf("tbl%0d.cnt_idle", i), ca, 0);
    end

    // Falling-edge latency: rising edge ignored, falling edge lands 3 clocks later.
    i_len = 5'd4; i_edge_sel = 1'b1; i_auto = 1'b0;
    i_clr = 1'b1; tick(1); i_clr = 1'b0;
    i_cs_n = 1'b0; tick(5);
    i_sck = 1'b1; tick(4);
    chk("lat.rise_ignored", int'(o_cnt), 0);
    i_sck = 1'b0; tick(2);
    chk("lat.cnt_at2", int'(o_cnt), 0);
    chk("lat.evt_at2", int'(o_sck_evt), 0);
    tick(1);
    chk("lat.cnt_at3", int'(o_cnt), 1);
    chk("lat.evt_at3", int'(o_sck_evt), 1);
    tick(1);
    chk("lat.evt_pulse", int'(o_sck_evt), 0);
    i_cs_n = 1'b1; tick(5);

    // Build up frames/ovf, then enable gating and clear mid-frame.
    i_edge_sel = 1'b0; i_len = 5'd2;
    i_cs_n = 1'b0; tick(5); pulses(3);
    chk("clr.pre_ovf", int'(o_ovf), 1);
    i_cs_n = 1'b1; tick(5);
    i_len = 5'd8; i_cs_n = 1'b0; tick(5);
    pulses(2);
    i_en = 1'b0; pulses(4);
    chk("en.hold", int'(o_cnt), 2);
    i_en = 1'b1; pulses(4);
    chk("en.resume", int'(o_cnt), 6);
    d0 = done_seen; a0 = abort_seen;
    i_clr = 1'b1; tick(1); i_clr = 1'b0;
    chk("clr.cnt", int'(o_cnt), 0);
    chk("clr.frames", int'(o_frames), 0);
    chk("clr.ovf", int'(o_ovf), 0);
    tick(2);
    chk("clr.no_pulse", (done_seen - d0) + (abort_seen - a0), 0);
    pulses(1);
    chk("clr.restart", int'(o_cnt), 1);

    // Shrinking i_len mid-frame, then async reset with o_last high.
    i_len = 5'd2; i_auto = 1'b1; pulses(1);
    chk("shrink.frames", int'(o_frames), 1);
    pulses(1);
    chk("rst2.pre_last", int'(o_last), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst2.cnt", int'(o_cnt), 0);
    chk("rst2.frames", int'(o_frames), 0);
    chk("rst2.last", int'(o_last), 0);
    #1 i_rst_n = 1'b1;
    tick(5); pulses(1);
    chk("rst2.restart", int'(o_cnt), 1);
    i_cs_n = 1'b1; tick(5);

    // New i_len below the count completes on the next edge.
    i_auto = 1'b0; i_len = 5'd8;
    i_cs_n = 1'b0; tick(5); pulses(5);
    d0 = done_seen;
    i_len = 5'd3; pulses(1);
    chk("short.cnt", int'(o_cnt), 3);
    chk("short.done", done_seen - d0, 1);
    a0 = abort_seen;
    i_cs_n = 1'b1; tick(5);
    chk("short.no_abort", abort_seen - a0, 0);

    // SCK edge coincident with CS_n deassert: deassert wins.
    i_len = 5'd8; i_cs_n = 1'b0; tick(5); pulses(2);
    d0 = done_seen; a0 = abort_seen;
    i_sck = 1'b1; i_cs_n = 1'b1; tick(5);
    i_sck = 1'b0; tick(3);
    chk("race.abort", abort_seen - a0, 1);
    chk("race.done", done_seen - d0, 0);
    chk("race.cnt", int'(o_cnt), 0);

    // Randomized frames against the arithmetic model.
    i_clr = 1'b1; tick(1); i_clr = 1'b0;
    m_frames = 0; m_ovf = 0;
    for (int i = 0; i < 25; i++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 6));
      au  = int'($urandom_range(0, 1));
      es  = int'($urandom_range(0, 1));
      n   = int'($urandom_range(0, 20));
      e = model(len, au, n);
      run_vec(len, au, es, n, 1'b0, o, ca);
      chk_obs($sformatf("rnd%0d(L%0d A%0d E%0d N%0d)", i, len, au, es, n), o, e);
      m_frames = e.frames; m_ovf = e.ovf;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
